// File: rtl/tone_oscillator.sv
// Square-wave tone generator with a linear attack/release envelope.
// Pitch changes are deferred to half-period boundaries so no runt pulses appear.
module tone_oscillator #(
  parameter int WIDTH    = 16,
  parameter int RAMP_DIV = 1200
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] divider,
  input  logic             en,
  output logic             wave,
  output logic [7:0]       sample,
  output logic [7:0]       amp,
  output logic             busy,
  output logic             period_done
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(RAMP_DIV - 1);

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] active_div, div_nxt;
  logic [PW-1:0]    presc, presc_nxt;
  logic             wave_nxt;
  logic [7:0]       amp_nxt;
  logic             pd_nxt;
  logic             note_on;
  logic             pre_wrap;
  logic             half_end;

  // Offset-binary sample: half the amplitude above or below mid-scale.
  function automatic logic [7:0] sample_of(input logic w, input logic [7:0] a);
    logic [7:0] half;
    half = {1'b0, a[7:1]};
    return w ? (8'd128 + half) : (8'd128 - half);
  endfunction

  assign note_on  = en && (divider != '0);
  assign pre_wrap = (presc == PRE_LAST);
  assign half_end = (cnt == active_div - WIDTH'(1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    div_nxt   = active_div;
    presc_nxt = presc;
    wave_nxt  = wave;
    amp_nxt   = amp;
    pd_nxt    = 1'b0;

    if (state != IDLE) begin
      if (half_end) begin
        cnt_nxt  = '0;
        wave_nxt = ~wave;
        pd_nxt   = wave;
        if (divider != '0) div_nxt = divider;
      end else begin
        cnt_nxt = cnt + WIDTH'(1);
      end
    end

    unique case (state)
      IDLE: begin
        cnt_nxt  = '0;
        wave_nxt = 1'b0;
        amp_nxt  = 8'd0;
        pd_nxt   = 1'b0;
        if (note_on) begin
          state_nxt = ATTACK;
          div_nxt   = divider;
          presc_nxt = '0;
        end
      end
      ATTACK: begin
        if (!note_on) begin
          state_nxt = RELEASE;
          presc_nxt = '0;
        end else if (amp == 8'hFF) begin
          state_nxt = SUSTAIN;
        end else begin
          presc_nxt = pre_wrap ? '0 : presc + PW'(1);
          if (pre_wrap) begin
            amp_nxt = amp + 8'd1;
            if (amp == 8'hFE) state_nxt = SUSTAIN;
          end
        end
      end
      SUSTAIN: begin
        if (!note_on) begin
          state_nxt = RELEASE;
          presc_nxt = '0;
        end
      end
      RELEASE: begin
        if (note_on) begin
          state_nxt = ATTACK;
          presc_nxt = '0;
        end else if (amp == 8'd0) begin
          state_nxt = IDLE;
          wave_nxt  = 1'b0;
          cnt_nxt   = '0;
          pd_nxt    = 1'b0;
        end else begin
          presc_nxt = pre_wrap ? '0 : presc + PW'(1);
          if (pre_wrap) begin
            amp_nxt = amp - 8'd1;
            // Last step lands on silence: park the oscillator immediately.
            if (amp == 8'd1) begin
              state_nxt = IDLE;
              wave_nxt  = 1'b0;
              cnt_nxt   = '0;
              pd_nxt    = 1'b0;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      cnt         <= '0;
      active_div  <= '0;
      presc       <= '0;
      wave        <= 1'b0;
      amp         <= 8'd0;
      sample      <= 8'd128;
      busy        <= 1'b0;
      period_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      active_div  <= div_nxt;
      presc       <= presc_nxt;
      wave        <= wave_nxt;
      amp         <= amp_nxt;
      sample      <= sample_of(wave, amp);
      busy        <= (state_nxt != IDLE);
      period_done <= pd_nxt;
    end
  end

endmodule
